sdram_host_port: RTL and testbench

Host-side initiator for the SDRAM controller's request interface (`wr_*`, `rd_*`, `busy`, `rd_ready`). It accepts buffered write requests from the game/drawer logic and blocking read requests from the pixel path. It arbitrates between them and drives the controller with single-cycle enable pulses, then returns read data to the requester. It sits between the drawer/game logic and `sdram_controller`, in the 166 MHz SDRAM clock domain.

---
 rtl/sdram_host_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/sdram_host_port.sv | 182 ++++++++++++++++++
 tb/tb_sdram_host_port.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_host_pkg.sv
// Shared types for the SDRAM host port: FSM states, the queued write request, default widths.
// Combinational definitions only; no logic and no flow control of its own.
package sdram_host_pkg;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } host_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head; a new entry becomes visible one cycle after its push.
// Push is ignored when full unless a pop happens in the same cycle; pop is ignored while the head is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_mem_cnt;
  logic [CW-1:0]    r_total;
  logic [WIDTH-1:0] r_head;
  logic             r_head_vld;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [CW-1:0]    w_total_nxt;

  assign w_push      = i_push && (!r_full || i_pop);
  assign w_pop       = i_pop && r_head_vld;
  // Refill the head from storage whenever it is empty or being consumed.
  assign w_load      = (r_mem_cnt != '0) && (!r_head_vld || w_pop);
  assign w_total_nxt = r_total + CW'(w_push) - CW'(w_pop);

  assign o_head_dat = r_head;
  assign o_full     = r_full;
  assign o_empty    = !r_head_vld;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_total    <= '0;
      r_head     <= '0;
      r_head_vld <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_load);
      r_total   <= w_total_nxt;
      r_full    <= (w_total_nxt == CW'(DEPTH));
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_load) begin
        r_head     <= r_mem[r_rptr];
        r_rptr     <= r_rptr + PW'(1);
        r_head_vld <= 1'b1;
      end else if (w_pop) begin
        r_head_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_host_port.sv
// Arbitrates queued writes and blocking reads onto the SDRAM controller; read issue 1 cycle after r_req, r_valid 1 cycle after rd_ready.
// Writers are stalled by w_ready when the FIFO is full; nothing leaves IDLE while the controller is busy.
module sdram_host_port
  import sdram_host_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_valid,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_err,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  input  logic              busy,
  output logic [7:0]        wr_timeouts
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  host_state_t r_state;
  host_state_t w_state_nxt;
  logic [TW-1:0] r_tmo;
  logic          r_busy_seen;

  wreq_t w_push_req;
  wreq_t w_head;
  logic  w_full;
  logic  w_empty;
  logic  w_fifo_push;
  logic  w_tmo_hit;
  logic  w_in_wait;
  logic  w_issue_wr;
  logic  w_issue_rd;
  logic  w_wait_entry;
  logic  w_rd_done;
  logic  w_rd_tmo;
  logic  w_wr_tmo;

  assign w_push_req  = '{addr: w_addr, data: w_data};
  assign w_ready     = !w_full;
  assign w_fifo_push = w_valid && w_ready;
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_in_wait   = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);

  sync_fifo #(
    .WIDTH ($bits(wreq_t)),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_fifo_push),
    .i_push_dat (w_push_req),
    .i_pop      (w_issue_wr),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue_wr   = 1'b0;
    w_issue_rd   = 1'b0;
    w_wait_entry = 1'b0;
    w_rd_done    = 1'b0;
    w_rd_tmo     = 1'b0;
    w_wr_tmo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A full FIFO outranks a waiting read so writers cannot starve.
        if (!busy) begin
          if (w_full && !w_empty) begin
            w_issue_wr  = 1'b1;
            w_state_nxt = ST_WR_ISSUE;
          end else if (r_req) begin
            w_issue_rd  = 1'b1;
            w_state_nxt = ST_RD_ISSUE;
          end else if (!w_empty) begin
            w_issue_wr  = 1'b1;
            w_state_nxt = ST_WR_ISSUE;
          end
        end
      end
      ST_WR_ISSUE: begin
        w_wait_entry = 1'b1;
        w_state_nxt  = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (r_busy_seen && !busy) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          // Busy that never rose counts as a completed write, not an abort.
          w_wr_tmo    = r_busy_seen || busy;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        w_wait_entry = 1'b1;
        w_state_nxt  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_ready) begin
          w_rd_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_rd_tmo    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_enable   <= 1'b0;
      rd_enable   <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      r_data      <= '0;
      wr_timeouts <= '0;
      r_tmo       <= '0;
      r_busy_seen <= 1'b0;
    end else begin
      wr_enable <= w_issue_wr;
      rd_enable <= w_issue_rd;
      r_valid   <= w_rd_done || w_rd_tmo;
      r_err     <= w_rd_tmo;
      if (w_issue_wr) begin
        wr_addr <= w_head.addr;
        wr_data <= w_head.data;
      end
      if (w_issue_rd) begin
        rd_addr <= r_addr;
      end
      if (w_rd_done) begin
        r_data <= rd_data;
      end else if (w_rd_tmo) begin
        r_data <= '0;
      end
      if (w_wait_entry) begin
        r_tmo       <= '0;
        r_busy_seen <= 1'b0;
      end else if (w_in_wait) begin
        r_tmo <= r_tmo + TW'(1);
        if (r_state == ST_WR_WAIT && busy) begin
          r_busy_seen <= 1'b1;
        end
      end
      if (w_wr_tmo && wr_timeouts != 8'hFF) begin
        wr_timeouts <= wr_timeouts + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_host_port.sv
// Directed bench for sdram_host_port with a behavioural controller model and command/response scoreboards.
module tb_sdram_host_port;
  import sdram_host_pkg::*;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_valid;
  logic [21:0] w_addr;
  logic [15:0] w_data;
  logic        w_ready;
  logic        r_req;
  logic [21:0] r_addr;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_err;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_enable;
  logic [21:0] rd_addr;
  logic        rd_enable;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic        busy;
  logic [7:0]  wr_timeouts;

  sdram_host_port #(.ADDR_W(22), .DATA_W(16), .WFIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready), .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .r_err(r_err), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .wr_timeouts(wr_timeouts)
  );

  always #5 clk = ~clk;

  // Controller model: busy for busy_len cycles after wr_enable, rd_ready rd_lat cycles after rd_enable.
  int   busy_len = 5;
  int   rd_lat   = 7;
  int   busy_cnt = 0;
  int   rd_cnt   = 0;
  logic force_busy = 1'b0;
  logic [15:0] rd_ret = 16'h0;
  int   cyc = 0;

  assign busy     = force_busy || (busy_cnt > 0);
  assign rd_ready = (rd_cnt == 1);
  assign rd_data  = rd_ret;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_enable) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (rd_enable && rd_lat > 0) rd_cnt <= rd_lat + 1;
    else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
  end

  typedef struct {
    bit          is_rd;
    logic [21:0] addr;
    logic [15:0] data;
  } cmd_t;
  typedef struct {
    logic [15:0] data;
    bit          err;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   last_rd_en_cyc = 0;
  int   last_rdy_cyc   = 0;
  int   rv_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    if (rd_ready) last_rdy_cyc = cyc;
    if (wr_enable || rd_enable) begin
      check("en_exclusive", 32'(wr_enable & rd_enable), 32'd0);
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd", 32'(cmd_q.size()), 32'd1);
      end else begin
        c = cmd_q.pop_front();
        check("cmd_kind", 32'(rd_enable), 32'(c.is_rd));
        if (c.is_rd) begin
          check("rd_addr", 32'(rd_addr), 32'(c.addr));
        end else begin
          check("wr_addr", 32'(wr_addr), 32'(c.addr));
          check("wr_data", 32'(wr_data), 32'(c.data));
        end
      end
      if (rd_enable) last_rd_en_cyc = cyc;
    end
    if (r_valid) begin
      rv_seen++;
      if (rsp_q.size() == 0) begin
        check("unexpected_rvalid", 32'(rsp_q.size()), 32'd1);
      end else begin
        r = rsp_q.pop_front();
        check("r_data", 32'(r_data), 32'(r.data));
        check("r_err", 32'(r_err), 32'(r.err));
        if (r.err) check("rd_timeout_lat", 32'(cyc - last_rd_en_cyc), 32'(TMO + 1));
        else       check("rd_return_lat", 32'(cyc - last_rdy_cyc), 32'd1);
      end
    end
  end

  task automatic push_wr(input logic [21:0] a, input logic [15:0] d);
    cmd_t c;
    c.is_rd = 1'b0; c.addr = a; c.data = d;
    cmd_q.push_back(c);
    w_valid = 1'b1; w_addr = a; w_data = d;
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  function automatic cmd_t rd_cmd(input logic [21:0] a);
    cmd_t c;
    c.is_rd = 1'b1; c.addr = a; c.data = 16'h0;
    return c;
  endfunction

  task automatic start_rd(input logic [21:0] a, input logic [15:0] d, input bit err);
    rsp_t r;
    r.data = d; r.err = err;
    rsp_q.push_back(r);
    rd_ret = d; r_addr = a; r_req = 1'b1;
  endtask

  task automatic wait_rvalid(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (r_valid) begin got = 1'b1; break; end
    end
    r_req = 1'b0;
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_q.size() == 0 && rsp_q.size() == 0 && dut.r_state == ST_IDLE && !busy) begin
        done = 1'b1; break;
      end
    end
    check(tag, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_enable"}, 32'(wr_enable), 32'd0);
    check({tag, "_rd_enable"}, 32'(rd_enable), 32'd0);
    check({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    check({tag, "_r_err"}, 32'(r_err), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_r_data"}, 32'(r_data), 32'd0);
    check({tag, "_wr_timeouts"}, 32'(wr_timeouts), 32'd0);
  endtask

  initial begin
    int lat;
    bit got;
    rst_n = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0; r_req = 1'b0; r_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("w_ready_after_reset", 32'(w_ready), 32'd1);
    @(posedge clk); #1;

    // Single write: accepted at edge N, wr_enable visible after edge N+2.
    push_wr(22'h000123, 16'hBEEF);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_enable) begin lat = i; break; end
    end
    check("wr_accept_lat", 32'(lat), 32'd2);
    drain("drain_single_wr", 50);
    check("idle_after_wr", 32'(dut.r_state), 32'(ST_IDLE));
    check("w_ready_after_wr", 32'(w_ready), 32'd1);

    // Single read: rd_enable the cycle after r_req, data returned 7 cycles later.
    rd_lat = 7;
    cmd_q.push_back(rd_cmd(22'h00ABCD));
    start_rd(22'h00ABCD, 16'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rd_issue_lat", 32'(rd_enable), 32'd1);
    wait_rvalid("read_done", 40);
    drain("drain_read", 20);

    // Fill the FIFO while busy; full write wins first, then read priority applies.
    force_busy = 1'b1;
    push_wr(22'h000010, 16'hA001);
    push_wr(22'h000011, 16'hA002);
    push_wr(22'h000012, 16'hA003);
    push_wr(22'h000013, 16'hA004);
    @(negedge clk);
    check("w_ready_full", 32'(w_ready), 32'd0);
    @(posedge clk); #1;
    cmd_q.insert(1, rd_cmd(22'h000200));
    start_rd(22'h000200, 16'h5A5A, 1'b0);
    force_busy = 1'b0;
    wait_rvalid("read_after_full", 200);
    drain("drain_full", 200);
    check("w_ready_drained", 32'(w_ready), 32'd1);

    // One queued write with a read pending: read goes first.
    force_busy = 1'b1;
    push_wr(22'h000300, 16'hC0DE);
    cmd_q.insert(0, rd_cmd(22'h000301));
    start_rd(22'h000301, 16'h7E57, 1'b0);
    @(posedge clk); #1 force_busy = 1'b0;
    wait_rvalid("read_before_write", 100);
    drain("drain_rd_wr", 100);

    // Read that never returns: error response TMO+1 cycles after rd_enable.
    rd_lat = 0;
    cmd_q.push_back(rd_cmd(22'h3FFFFF));
    start_rd(22'h3FFFFF, 16'h0000, 1'b1);
    wait_rvalid("read_timeout", 150);
    drain("drain_rd_tmo", 20);

    // Write whose busy never falls in time is counted; one that never raises busy is not.
    check("wr_timeouts_zero", 32'(wr_timeouts), 32'd0);
    busy_len = 80;
    push_wr(22'h000400, 16'hDEAD);
    drain("drain_wr_stuck", 300);
    check("wr_timeouts_one", 32'(wr_timeouts), 32'd1);
    busy_len = 0;
    push_wr(22'h000401, 16'hFACE);
    drain("drain_wr_nobusy", 200);
    check("wr_timeouts_still_one", 32'(wr_timeouts), 32'd1);
    busy_len = 5;

    // Reset in RD_WAIT: outputs clear, the late rd_ready produces nothing.
    rd_lat = 10;
    cmd_q.push_back(rd_cmd(22'h000500));
    rd_ret = 16'h9999; r_addr = 22'h000500; r_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_enable) begin got = 1'b1; break; end
    end
    check("rst_case_rd_issue", 32'(got), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; r_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    rv_seen = 0;
    repeat (20) @(negedge clk);
    check("no_rvalid_after_reset", 32'(rv_seen), 32'd0);
    check("w_ready_after_midreset", 32'(w_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
